// File: rtl/alu_wide_seq_if.sv
// ----------------------------------------------------------------------------
// alu_wide_seq_if
// Request/response bundle between the execute-stage control and the wide ALU
// sequencer. One request carries a command, a carry-in and two operands of
// WORDS 32-bit limbs. The response carries the wide result and NZCV flags.
//
// Signals
//   startValid / startReady   request handshake (accept on both high)
//   cmd [1:0]                 00 ADD, 01 ADC, 10 AND, 11 EOR
//   carryIn                   carry into limb 0 for ADC
//   opA, opB [32*WORDS-1:0]   operands
//   result [32*WORDS-1:0]     wide result
//   cFlag zFlag nFlag vFlag   wide flags
//   resultValid / resultReady response handshake
//
// Modports
//   master : execute-stage control (issues requests, consumes results)
//   slave  : the sequencer
// ----------------------------------------------------------------------------
interface alu_wide_seq_if #(
   parameter int WORDS = 2
);
   logic                   startValid;
   logic                   startReady;
   logic [1:0]             cmd;
   logic                   carryIn;
   logic [32*WORDS-1:0]    opA;
   logic [32*WORDS-1:0]    opB;
   logic [32*WORDS-1:0]    result;
   logic                   cFlag;
   logic                   zFlag;
   logic                   nFlag;
   logic                   vFlag;
   logic                   resultValid;
   logic                   resultReady;

   modport master (
      output startValid, cmd, carryIn, opA, opB, resultReady,
      input  startReady, result, cFlag, zFlag, nFlag, vFlag, resultValid
   );

   modport slave (
      input  startValid, cmd, carryIn, opA, opB, resultReady,
      output startReady, result, cFlag, zFlag, nFlag, vFlag, resultValid
   );
endinterface

// File: rtl/alu_wide_seq.sv
// ----------------------------------------------------------------------------
// alu_wide_seq
// Runs a WORDS-limb (32*WORDS-bit) ADD/ADC/AND/EOR on the shared 32-bit ALU,
// one limb per clock, rippling the carry from limb to limb. The wide result
// and NZCV flags are returned over a valid/ready handshake.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high
//   bus        request/response bundle (slave side of alu_wide_seq_if)
//   aluA/aluB  32-bit operands to the ALU
//   aluOp      5-bit ALU opcode (5'b11111 is the ALU idle opcode, out=0)
//   aluCin     carry into the ALU
//   aluOut     ALU result, combinational in the same cycle
//   aluC/Z/N/V ALU flags, combinational in the same cycle
// ----------------------------------------------------------------------------
module alu_wide_seq #(
   parameter int WORDS = 2
) (
   input  logic        clk,
   input  logic        reset,
   alu_wide_seq_if.slave bus,
   output logic [31:0] aluA,
   output logic [31:0] aluB,
   output logic [4:0]  aluOp,
   output logic        aluCin,
   input  logic [31:0] aluOut,
   input  logic        aluC,
   input  logic        aluZ,
   input  logic        aluN,
   input  logic        aluV
);

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
   typedef enum logic [1:0] {CMD_ADD, CMD_ADC, CMD_AND, CMD_EOR} cmd_t;

   localparam int            KW      = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [KW-1:0] LAST    = KW'(WORDS - 1);
   localparam logic [4:0]    OP_ADDS = 5'b01011;
   localparam logic [4:0]    OP_ADC  = 5'b00101;
   localparam logic [4:0]    OP_AND  = 5'b01000;
   localparam logic [4:0]    OP_EOR  = 5'b01001;
   localparam logic [4:0]    OP_NONE = 5'b11111;

   state_t                 state, state_nxt;
   cmd_t                   cmd_q;
   logic                   cin_q;
   logic [WORDS-1:0][31:0] opa_q, opb_q, result_q;
   logic [KW-1:0]          k;
   logic                   carry_q, zacc_q;
   logic                   c_q, z_q, n_q, v_q;
   logic                   accept, last_limb;

   assign accept    = (state == IDLE) && bus.startValid;
   assign last_limb = (k == LAST);

   assign bus.result = result_q;
   assign bus.cFlag  = c_q;
   assign bus.zFlag  = z_q;
   assign bus.nFlag  = n_q;
   assign bus.vFlag  = v_q;

   // NOTE: state is written with <= so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // NOTE: every output gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt       = state;
      bus.startReady  = 1'b0;
      bus.resultValid = 1'b0;
      aluA            = '0;
      aluB            = '0;
      aluOp           = OP_NONE;
      aluCin          = 1'b0;
      case (state)
         IDLE: begin
            bus.startReady = 1'b1;
            if (bus.startValid) state_nxt = EXEC;
         end
         EXEC: begin
            aluA = opa_q[k];
            aluB = opb_q[k];
            case (cmd_q)
               CMD_ADD: begin
                  // Limb 0 is a plain ADD; upper limbs add with the rippled carry.
                  if (k == '0) begin
                     aluOp = OP_ADDS;
                  end else begin
                     aluOp  = OP_ADC;
                     aluCin = carry_q;
                  end
               end
               CMD_ADC: begin
                  aluOp  = OP_ADC;
                  aluCin = (k == '0) ? cin_q : carry_q;
               end
               CMD_AND: aluOp = OP_AND;
               CMD_EOR: aluOp = OP_EOR;
               default: aluOp = OP_NONE;
            endcase
            if (last_limb) state_nxt = DONE;
         end
         DONE: begin
            bus.resultValid = 1'b1;
            if (bus.resultReady) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: the operand latches carry no reset; they are only read in EXEC,
   // which is always entered through an accept that loads them.
   always_ff @(posedge clk) begin
      if (accept) begin
         cmd_q <= cmd_t'(bus.cmd);
         cin_q <= bus.carryIn;
         opa_q <= bus.opA;
         opb_q <= bus.opB;
      end
   end

   // Limb datapath: collect one 32-bit slice per EXEC cycle, ripple carry,
   // AND-accumulate the per-limb zero flags, publish flags after the last limb.
   always_ff @(posedge clk) begin
      if (reset) begin
         result_q <= '0;
         k        <= '0;
         carry_q  <= 1'b0;
         zacc_q   <= 1'b1;
         c_q      <= 1'b0;
         z_q      <= 1'b0;
         n_q      <= 1'b0;
         v_q      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  k      <= '0;
                  zacc_q <= 1'b1;
               end
            end
            EXEC: begin
               result_q[k] <= aluOut;
               carry_q     <= aluC;
               zacc_q      <= zacc_q & aluZ;
               k           <= k + KW'(1);
               if (last_limb) begin
                  c_q <= aluC;
                  z_q <= zacc_q & aluZ;
                  n_q <= aluN;
                  v_q <= aluV;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
